// File: rtl/riscv_div_unit.sv
// riscv_div_unit: iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle. Divide-by-zero and signed overflow finish on the accept edge.
module riscv_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_fn3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            is_rem_q, q_neg_q, r_neg_q;

    logic            unused_fn3;
    logic            is_signed, rs1_neg, rs2_neg, div_zero, ovf, accept;
    logic [XLEN-1:0] fast_result;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] quo_n, rem_n, final_result;

    // fn3[2] only tells issue to route here; the op is fully decoded by fn3[1:0].
    assign unused_fn3 = in_fn3[2];

    // Accept decode, fast-path detection and one restoring-division step.
    always_comb begin
        is_signed = !in_fn3[0];
        rs1_neg   = is_signed && in_rs1[XLEN-1];
        rs2_neg   = is_signed && in_rs2[XLEN-1];
        div_zero  = (in_rs2 == '0);
        ovf       = is_signed && (in_rs1 == MIN_NEG) && (in_rs2 == '1);
        accept    = in_valid && (state_q == IDLE) && !flush;

        fast_result = '0;
        if (div_zero) begin
            fast_result = in_fn3[1] ? in_rs1 : '1;
        end else if (ovf) begin
            fast_result = in_fn3[1] ? '0 : MIN_NEG;
        end

        // The compare is one bit wider than XLEN; the difference always fits in XLEN bits.
        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        quo_n   = {quo_q[XLEN-2:0], ge};
        rem_n   = ge ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];

        final_result = is_rem_q ? (r_neg_q ? -rem_n : rem_n)
                                : (q_neg_q ? -quo_n : quo_n);
    end

    // Next-state logic and handshake outputs; flush wins over accept and completion.
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (accept) state_d = (div_zero || ovf) ? DONE : CALC;
                CALC: if (cnt_q == CW'(XLEN-1)) state_d = DONE;
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            is_rem_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            quo_q    <= rs1_neg ? -in_rs1 : in_rs1;
            dvs_q    <= rs2_neg ? -in_rs2 : in_rs2;
            rem_q    <= '0;
            is_rem_q <= in_fn3[1];
            q_neg_q  <= rs1_neg ^ rs2_neg;
            r_neg_q  <= rs1_neg;
            out_rd   <= in_rd;
            if (div_zero || ovf) out_result <= fast_result;
        end else if ((state_q == CALC) && !flush) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) out_result <= final_result;
        end
    end

endmodule
